// File: rtl/pr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pr_pkg
// Shared defaults and output-shape encodings for the priority decoder.
// Revision: 1.0
// ---------------------------------------------------------------------------
package pr_pkg;

  // Default decoded word width.
  localparam int NUM_SIZE_DEFAULT = 16;

  // Output shape selected by the mode input.
  typedef enum logic {
    MODE_ONEHOT = 1'b0,
    MODE_THERMO = 1'b1
  } mode_e;

endpackage : pr_pkg
`default_nettype wire

// File: rtl/pr_dec_core.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pr_dec_core
// Combinational decode of a priority index into a one-hot or thermometer
// word. An index beyond the word width yields an all-zero word and err.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pr_dec_core
  import pr_pkg::*;
#(
  parameter int NUM_SIZE = NUM_SIZE_DEFAULT,
  parameter int OUT_SIZE = $clog2(NUM_SIZE)
) (
  input  logic [OUT_SIZE-1:0] idx,
  input  logic                mode,
  output logic [NUM_SIZE-1:0] num,
  output logic                err
);

  // Build the word bit by bit; thermometer fills idx..0, one-hot only idx.
  always_comb begin
    num = '0;
    err = 1'b0;
    if (int'(idx) >= NUM_SIZE) begin
      err = 1'b1;
    end else begin
      for (int i = 0; i < NUM_SIZE; i++) begin
        if (mode == MODE_THERMO) begin
          num[i] = (i <= int'(idx));
        end else begin
          num[i] = (i == int'(idx));
        end
      end
    end
  end

endmodule : pr_dec_core
`default_nettype wire

// File: rtl/pr_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pr_decoder
// Registered priority-index decoder with a two-entry (output + skid)
// ready/valid buffer and a sticky out-of-range flag.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pr_decoder
  import pr_pkg::*;
#(
  parameter int NUM_SIZE = NUM_SIZE_DEFAULT,
  parameter int OUT_SIZE = $clog2(NUM_SIZE)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OUT_SIZE-1:0] idx,
  input  logic                mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_SIZE-1:0] num,
  output logic                err,
  output logic                err_seen
);

  logic [NUM_SIZE-1:0] dec_num;
  logic                dec_err;
  logic                skid_valid;
  logic [NUM_SIZE-1:0] skid_num;
  logic                skid_err;
  logic                accept;
  logic                out_free;

  pr_dec_core #(
    .NUM_SIZE (NUM_SIZE),
    .OUT_SIZE (OUT_SIZE)
  ) u_core (
    .idx  (idx),
    .mode (mode),
    .num  (dec_num),
    .err  (dec_err)
  );

  // in_ready is simply the inverse of the registered skid occupancy.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  // The output register can take a new word when empty or draining now.
  assign out_free = ~out_valid | out_ready;

  // Output/skid buffer: skid refills the output first, so order is kept;
  // while the skid is full in_ready is low, so no accept collides with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      num        <= '0;
      err        <= 1'b0;
      skid_valid <= 1'b0;
      skid_num   <= '0;
      skid_err   <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        num        <= skid_num;
        err        <= skid_err;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        num       <= dec_num;
        err       <= dec_err;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_num   <= dec_num;
      skid_err   <= dec_err;
    end
  end

  // Sticky error flag, set by any accepted out-of-range index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_seen <= 1'b0;
    end else if (accept && dec_err) begin
      err_seen <= 1'b1;
    end
  end

endmodule : pr_decoder
`default_nettype wire

// File: tb/tb_pr_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pr_decoder
// Directed bench for pr_decoder at NUM_SIZE 16 and 12.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pr_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        rst_n_a, in_valid_a, in_ready_a, mode_a, out_valid_a, out_ready_a;
  logic        err_a, err_seen_a;
  logic [3:0]  idx_a;
  logic [15:0] num_a;

  // 12-bit instance
  logic        rst_n_b, in_valid_b, in_ready_b, mode_b, out_valid_b, out_ready_b;
  logic        err_b, err_seen_b;
  logic [3:0]  idx_b;
  logic [11:0] num_b;

  int vectors = 0;
  int miscompares = 0;

  pr_decoder #(.NUM_SIZE(16)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .idx(idx_a), .mode(mode_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .num(num_a), .err(err_a), .err_seen(err_seen_a)
  );

  pr_decoder #(.NUM_SIZE(12)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .idx(idx_b), .mode(mode_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .num(num_b), .err(err_b), .err_seen(err_seen_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock, then sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference priority coder: position of highest set bit, -1 for zero.
  function automatic int prio(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) if (w[i]) return i;
    return -1;
  endfunction

  initial begin
    int exp_w;
    rst_n_a = 0; in_valid_a = 0; idx_a = 0; mode_a = 0; out_ready_a = 1;
    rst_n_b = 0; in_valid_b = 0; idx_b = 0; mode_b = 0; out_ready_b = 1;
    step(); step();

    // Reset state
    check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready_a},  32'd1);
    check("rst_num",       {16'd0, num_a},       32'd0);
    check("rst_err",       {31'd0, err_a},       32'd0);
    check("rst_err_seen",  {31'd0, err_seen_a},  32'd0);

    rst_n_a = 1; rst_n_b = 1;
    step();
    check("post_rst_in_ready", {31'd0, in_ready_a}, 32'd1);
    check("post_rst_out_valid", {31'd0, out_valid_a}, 32'd0);

    // Basic decodes, latency 1
    in_valid_a = 1; idx_a = 5; mode_a = 0;
    step();
    check("oh5_valid", {31'd0, out_valid_a}, 32'd1);
    check("oh5_num", {16'd0, num_a}, 32'h0020);
    check("oh5_err", {31'd0, err_a}, 32'd0);
    idx_a = 5; mode_a = 1;
    step();
    check("th5_num", {16'd0, num_a}, 32'h003F);
    idx_a = 15; mode_a = 1;
    step();
    check("th15_num", {16'd0, num_a}, 32'hFFFF);
    idx_a = 0; mode_a = 1;
    step();
    check("th0_num", {16'd0, num_a}, 32'h0001);
    idx_a = 15; mode_a = 0;
    step();
    check("oh15_num", {16'd0, num_a}, 32'h8000);
    in_valid_a = 0;
    step();
    check("idle_valid", {31'd0, out_valid_a}, 32'd0);

    // Back-pressure: three offers with out_ready low
    out_ready_a = 0; in_valid_a = 1; mode_a = 0; idx_a = 1;
    step();
    check("bp1_num", {16'd0, num_a}, 32'h0002);
    check("bp1_in_ready", {31'd0, in_ready_a}, 32'd1);
    idx_a = 2;
    step();
    check("bp2_in_ready", {31'd0, in_ready_a}, 32'd0);
    check("bp2_num_held", {16'd0, num_a}, 32'h0002);
    idx_a = 3;
    step();
    check("bp3_in_ready", {31'd0, in_ready_a}, 32'd0);
    check("bp3_num_held", {16'd0, num_a}, 32'h0002);
    check("bp3_valid_held", {31'd0, out_valid_a}, 32'd1);
    out_ready_a = 1;
    step();
    check("bp_drain_skid", {16'd0, num_a}, 32'h0004);
    check("bp_drain_ready", {31'd0, in_ready_a}, 32'd1);
    step();
    check("bp_third", {16'd0, num_a}, 32'h0008);
    in_valid_a = 0;
    step();
    check("bp_empty", {31'd0, out_valid_a}, 32'd0);

    // Sustained one word per cycle
    in_valid_a = 1; mode_a = 0;
    for (int i = 0; i < 8; i++) begin
      idx_a = 4'(i);
      step();
      check("stream_num", {16'd0, num_a}, 32'd1 << i);
      check("stream_ready", {31'd0, in_ready_a & out_valid_a}, 32'd1);
    end
    in_valid_a = 0;
    step();

    // Out-of-range on the 12-bit instance
    in_valid_b = 1; idx_b = 13; mode_b = 0;
    step();
    check("oor13_num", {20'd0, num_b}, 32'h000);
    check("oor13_err", {31'd0, err_b}, 32'd1);
    check("oor13_err_seen", {31'd0, err_seen_b}, 32'd1);
    idx_b = 11; mode_b = 1;
    step();
    check("ok11_num", {20'd0, num_b}, 32'hFFF);
    check("ok11_err", {31'd0, err_b}, 32'd0);
    check("ok11_err_seen", {31'd0, err_seen_b}, 32'd1);
    idx_b = 12; mode_b = 1;
    step();
    check("oor12_err", {31'd0, err_b}, 32'd1);
    check("oor12_num", {20'd0, num_b}, 32'h000);
    idx_b = 0; mode_b = 0;
    step();
    check("ok0_num", {20'd0, num_b}, 32'h001);
    check("ok0_err_seen", {31'd0, err_seen_b}, 32'd1);
    check("a_err_seen_clear", {31'd0, err_seen_a}, 32'd0);

    // Reset with both entries full
    out_ready_b = 0; idx_b = 2; mode_b = 0;
    step();
    idx_b = 3;
    step();
    check("full_in_ready", {31'd0, in_ready_b}, 32'd0);
    in_valid_b = 0; rst_n_b = 0;
    step();
    check("mid_rst_valid", {31'd0, out_valid_b}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready_b}, 32'd1);
    check("mid_rst_err_seen", {31'd0, err_seen_b}, 32'd0);
    rst_n_b = 1; out_ready_b = 1;
    step();
    step();
    check("after_rst_no_word", {31'd0, out_valid_b}, 32'd0);

    // Round trip through a reference priority coder
    in_valid_a = 1; out_ready_a = 1;
    for (int i = 0; i < 50; i++) begin
      idx_a  = 4'($urandom_range(0, 15));
      mode_a = 1'($urandom_range(0, 1));
      exp_w  = mode_a ? ((1 << (int'(idx_a) + 1)) - 1) : (1 << idx_a);
      step();
      check("rt_prio", prio({16'd0, num_a}), {28'd0, idx_a});
      check("rt_num", {16'd0, num_a}, exp_w);
    end
    in_valid_a = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pr_decoder
`default_nettype wire

// File: doc/pr_decoder.md
PR_DECODER -- requirements
Module: pr_decoder

Interface
REQ-001 SHALL have parameter NUM_SIZE, default 16, the decoded word width.
REQ-002 SHALL have parameter OUT_SIZE, default $clog2(NUM_SIZE), the index width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  the reset; synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  the index-word offer.
REQ-006 SHALL have port in_ready  output  1  the index-word acceptance.
REQ-007 SHALL have port idx  input  OUT_SIZE  the priority index (highest-set-bit position).
REQ-008 SHALL have port mode  input  1  the output shape: 0 = one-hot, 1 = thermometer.
REQ-009 SHALL have port out_valid  output  1  the decoded word offer.
REQ-010 SHALL have port out_ready  input  1  the downstream acceptance.
REQ-011 SHALL have port num  output  NUM_SIZE  the decoded word.
REQ-012 SHALL have port err  output  1  flags the idx >= NUM_SIZE word currently on num.
REQ-013 SHALL have port err_seen  output  1  sticky flag, set once any out-of-range idx is accepted.

Function
REQ-014 SHALL accept an input on any cycle where in_valid && in_ready are both high.
REQ-015 SHALL decode mode 0 to num with only bit idx set, so that priority coding of num returns idx.
REQ-016 SHALL decode mode 1 to num with bits idx..0 set, the largest word whose priority code is idx.
REQ-017 SHALL, when idx >= NUM_SIZE (non-power-of-2 NUM_SIZE only), produce num = 0 with err = 1 carried alongside that word; otherwise err = 0.
REQ-018 SHALL present an accepted word on num/out_valid the cycle after acceptance (latency 1) when the output register is empty or drains that same cycle.
REQ-019 SHALL hold a two-entry buffer: output register plus skid register; in_ready = !skid_valid, registered.
REQ-020 SHALL, when an input is accepted while out_valid && !out_ready, place it in the skid register.
REQ-021 SHALL, on out_valid && out_ready with skid valid, move skid to output and clear skid in the same cycle.
REQ-022 SHALL sustain one word per cycle with out_ready held high and no bubbles.
REQ-023 SHALL keep num, err and out_valid stable while out_valid && !out_ready.
REQ-024 SHALL deliver words in acceptance order with no loss or duplication.
REQ-025 SHALL set err_seen on the acceptance cycle + 1 of an erroneous idx; cleared only by reset.

Reset
REQ-026 SHALL, on clk edge with rst_n low, set out_valid = 0, skid_valid = 0, in_ready = 1, num = 0, err = 0, err_seen = 0.
REQ-027 SHALL discard buffered words when reset asserts mid-operation; no word is output after reset release until a new acceptance.
REQ-028 SHALL hold in_ready = 1 on the first cycle after reset release.

Structure
REQ-029 SHALL place the NUM_SIZE default and the mode encodings MODE_ONEHOT = 0 and MODE_THERMO = 1 in shared package pr_pkg.
REQ-030 SHALL isolate the combinational idx/mode -> {num, err} decode in sub-module pr_dec_core; pr_decoder holds only the buffer and handshake.

Verification
REQ-031 SHALL cover: NUM_SIZE=16, idx=5, mode=0, out_ready=1 -> next cycle num=16'h0020, err=0.
REQ-032 SHALL cover: idx=5, mode=1 -> num=16'h003F; idx=15, mode=1 -> num=16'hFFFF.
REQ-033 SHALL cover back-pressure: out_ready=0 with 3 consecutive offers idx=1,2,3 mode=0 -> in_ready low after the second acceptance, num held at 0x0002; out_ready=1 -> outputs 0x0002, 0x0004, 0x0008 in order.
REQ-034 SHALL cover: NUM_SIZE=12, idx=13 -> num=12'h000, err=1, err_seen=1 and remaining 1 after later valid words.
REQ-035 SHALL cover: rst_n low with both entries full -> next cycle out_valid=0, in_ready=1, err_seen=0.
REQ-036 SHALL cover round-trip: 50 random idx/mode through pr_decoder into pr_coder -> pr_coder out equals idx every word.
